// File: rtl/adsr_sample_writer.sv
// ADSR-gated sample writer between the tone generators and the audio controller.
// Samples at the audio rate, scales by the envelope, and writes both DAC channels.
module adsr_sample_writer #(
    parameter int unsigned SAMPLE_DIV    = 1042,
    parameter int unsigned ATTACK_STEP   = 64,
    parameter int unsigned DECAY_STEP    = 16,
    parameter logic [15:0] SUSTAIN_LEVEL = 16'hC000,
    parameter int unsigned RELEASE_STEP  = 8
) (
    input  logic        Clk,
    input  logic        resetn,
    input  logic        note_on,
    input  logic [31:0] sample_in,
    input  logic        audio_out_allowed,
    output logic        write_audio_out,
    output logic [31:0] left_channel_audio_out,
    output logic [31:0] right_channel_audio_out,
    output logic [15:0] env_level,
    output logic [2:0]  env_state,
    output logic        overrun
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ATTACK  = 3'd1,
        S_DECAY   = 3'd2,
        S_SUSTAIN = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] env_q, env_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] envp_q;
    logic [31:0] s_q;
    logic        mul_q;
    logic [31:0] out_q;
    logic        pend_q;
    logic        ovr_q;
    logic        tick;

    logic [16:0] up, dec, rel;
    logic [15:0] up_sat, dec_sat, rel_sat;
    logic signed [48:0] prod;
    logic [31:0] res;
    logic        unused_ok;

    assign tick = (cnt_q == 16'(SAMPLE_DIV - 1));

    // Saturating envelope step candidates, all computed in 17 bits
    always_comb begin
        up      = {1'b0, env_q} + 17'(ATTACK_STEP);
        dec     = {1'b0, env_q} - 17'(DECAY_STEP);
        rel     = {1'b0, env_q} - 17'(RELEASE_STEP);
        up_sat  = up[16] ? 16'hFFFF : up[15:0];
        dec_sat = (dec[16] || dec[15:0] < SUSTAIN_LEVEL) ? SUSTAIN_LEVEL : dec[15:0];
        rel_sat = rel[16] ? 16'h0000 : rel[15:0];
    end

    // Envelope FSM next state; only advances on a sample tick
    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        cnt_d   = tick ? 16'd0 : cnt_q + 16'd1;
        if (tick) begin
            unique case (state_q)
                S_IDLE: begin
                    env_d = 16'h0000;
                    if (note_on) begin
                        state_d = (up_sat == 16'hFFFF) ? S_DECAY : S_ATTACK;
                        env_d   = up_sat;
                    end
                end
                S_ATTACK, S_RELEASE: begin
                    if (note_on) begin
                        state_d = (up_sat == 16'hFFFF) ? S_DECAY : S_ATTACK;
                        env_d   = up_sat;
                    end else begin
                        state_d = (rel_sat == 16'h0000) ? S_IDLE : S_RELEASE;
                        env_d   = rel_sat;
                    end
                end
                S_DECAY: begin
                    if (!note_on) begin
                        state_d = (rel_sat == 16'h0000) ? S_IDLE : S_RELEASE;
                        env_d   = rel_sat;
                    end else begin
                        state_d = (dec_sat == SUSTAIN_LEVEL) ? S_SUSTAIN : S_DECAY;
                        env_d   = dec_sat;
                    end
                end
                S_SUSTAIN: begin
                    if (!note_on) begin
                        state_d = (rel_sat == 16'h0000) ? S_IDLE : S_RELEASE;
                        env_d   = rel_sat;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    env_d   = 16'h0000;
                end
            endcase
        end
    end

    // Tick counter, envelope state and sample capture
    always_ff @(posedge Clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
            env_q   <= '0;
            envp_q  <= '0;
            s_q     <= '0;
            mul_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            env_q   <= env_d;
            mul_q   <= tick;
            if (tick) begin
                s_q    <= sample_in;
                envp_q <= env_q;
            end
        end
    end

    // Scale by the pre-update envelope; floor shift keeps negatives rounding down
    always_comb begin
        prod = $signed(s_q) * $signed({1'b0, envp_q});
        res  = prod[47:16];
    end

    assign unused_ok = ^{prod[48], prod[15:0]};

    // Output holding register with single-entry pending flag and sticky overrun
    always_ff @(posedge Clk or negedge resetn) begin
        if (!resetn) begin
            out_q  <= '0;
            pend_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else if (mul_q) begin
            out_q  <= res;
            pend_q <= 1'b1;
            if (pend_q && !audio_out_allowed) ovr_q <= 1'b1;
        end else if (pend_q && audio_out_allowed) begin
            pend_q <= 1'b0;
        end
    end

    assign write_audio_out         = pend_q & audio_out_allowed;
    assign left_channel_audio_out  = out_q;
    assign right_channel_audio_out = out_q;
    assign env_level               = env_q;
    assign env_state               = state_q;
    assign overrun                 = ovr_q;

endmodule

// File: doc/adsr_sample_writer.md
Name: adsr_sample_writer

Overview:
- Downstream stage between the tone generators (sine/square) and Audio_Controller.
- Samples the selected generator's 32-bit signed output at the audio rate and scales it by an ADSR envelope driven by note press/release.
- Pushes the scaled sample to both DAC channels with the controller's audio_out_allowed / write_audio_out handshake.
- Replaces the current ungated, click-prone hookup where sound goes straight to the controller.

Parameters:
- SAMPLE_DIV, 1042: Clk cycles per sample tick (50 MHz / 1042 ≈ 48 kHz); legal range 4..65535.
- ATTACK_STEP, 64: envelope increment per sample in ATTACK.
- DECAY_STEP, 16: envelope decrement per sample in DECAY.
- SUSTAIN_LEVEL, 16'hC000: envelope floor in DECAY and hold level in SUSTAIN.
- RELEASE_STEP, 8: envelope decrement per sample in RELEASE.

Ports:
- Clk  in  1  system clock (CLOCK_50)
- resetn  in  1  asynchronous, active-low reset
- note_on  in  1  level; high while any note key is held (|noteSelector)
- sample_in  in  32  signed generator sample; may change on any cycle
- audio_out_allowed  in  1  controller output FIFO has space
- write_audio_out  out  1  one-cycle write strobe to controller
- left_channel_audio_out  out  32  signed scaled sample
- right_channel_audio_out  out  32  identical to left
- env_level  out  16  current envelope, unsigned, 0..16'hFFFF
- env_state  out  3  IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4
- overrun  out  1  sticky; a sample tick was lost

Behaviour:
- Reset (async assert, sync release): all outputs 0, state IDLE, tick counter 0, pending 0.
- Tick counter runs 0..SAMPLE_DIV-1 and wraps. tick = 1 on the cycle the counter equals SAMPLE_DIV-1.
- On tick (cycle t):
  - capture sample_in into s_reg;
  - apply one envelope update (FSM below);
  - the product uses env_level before the update.
- Cycle t+1: product = s_reg (signed 32) × {1'b0, env} (signed 17) → 49-bit signed. Result = product >>> 16 (arithmetic, floor), low 32 bits, loaded into both channel outputs; set pending.
- Write rule: when pending && audio_out_allowed, write_audio_out = 1 for exactly that cycle, and pending clears on the same edge. Earliest strobe is cycle t+2; it stays low otherwise. Channel outputs are stable while pending.
- Overrun: if a new result would load while pending = 1, the old sample is overwritten, overrun sets, and only one strobe is issued. Clear overrun only by reset.
- Samples stream in every state. IDLE produces 0-valued samples, keeping the DAC FIFO fed.
- Envelope FSM (evaluated only on tick; note_on sampled at tick):
  - IDLE: env = 0. note_on = 1 → ATTACK.
  - ATTACK: env = min(env + ATTACK_STEP, 16'hFFFF). Reaching 16'hFFFF → DECAY. note_on = 0 → RELEASE.
  - DECAY: env = max(env - DECAY_STEP, SUSTAIN_LEVEL). Reaching SUSTAIN_LEVEL → SUSTAIN. note_on = 0 → RELEASE.
  - SUSTAIN: env holds. note_on = 0 → RELEASE.
  - RELEASE: env = max(env - RELEASE_STEP, 0). Reaching 0 → IDLE. note_on = 1 → ATTACK from the current env (retrigger, no reset to 0).
- Each transition takes effect with that same tick's update. Release takes priority over the step: when note_on = 0 in A/D/S, the tick applies the RELEASE decrement.
- Arithmetic: all step math in 17 bits, then saturated. No wrap-around of env is allowed.
- note_on toggling between ticks is invisible; only tick-time values matter.
- Reset mid-write: the strobe drops immediately (async), and the pending sample is discarded.

Test Plan:
- Reset: hold resetn = 0, toggle Clk, audio_out_allowed = 1 → all outputs 0, no strobe. After release with SAMPLE_DIV = 4 → a strobe every 4 cycles carrying 0.
- Attack/decay: note_on = 1, sample_in = 10_000_000, allowed = 1 → env hits 16'hFFFF on the 1024th tick with output 9_999_847. env reaches 16'hC000 1024 ticks later, state SUSTAIN, output 7_500_000.
- Negative rounding: sample_in = -10_000_000 at env 16'hFFFF → output -9_999_848; at env 16'hC000 → -7_500_000.
- Release/retrigger: drop note_on in SUSTAIN → RELEASE, env 16'hC000 - 8 per tick. Reassert after 100 ticks → ATTACK from 16'hBCE0.
- Backpressure: allowed = 0 for 3 ticks → no strobes, overrun = 1. Raise allowed → exactly one strobe with the latest sample, and overrun stays 1.
- Async reset mid-RELEASE with pending = 1 → strobe never fires, state IDLE, env 0 immediately.
